// File: rtl/fetch_pkg.sv
// Shared types and helpers for the fetch/issue sequencer.
package fetch_pkg;

  localparam int unsigned WARP_NUM_DEF = 8;
  localparam int unsigned WID_W        = $clog2(WARP_NUM_DEF);

  typedef enum logic [1:0] {
    IDLE,
    REQ,
    MISS
  } fetch_state_t;

  // One-hot (or zero) to index. Bits are OR-ed together, so there is no priority chain.
  // Callers must not pass vectors wider than 32 bits.
  function automatic int unsigned onehot_to_idx(input logic [31:0] oh);
    int unsigned idx;
    idx = 0;
    for (int unsigned i = 0; i < 32; i++) begin
      if (oh[i]) idx |= i;
    end
    return idx;
  endfunction

endpackage

// File: rtl/fetch_issue_sequencer_if.sv
// Grant, I-cache and decode signals of the fetch/issue sequencer.
// The FETCH_PERF_CNT_EN macro adds the performance counter outputs.
interface fetch_issue_sequencer_if #(
  parameter int unsigned WARP_NUM = 8,
  parameter int unsigned PC_W     = 32
);
  localparam int unsigned WidW = $clog2(WARP_NUM);

  logic [WARP_NUM-1:0]      GRT_raw_1_RR_IF;
  logic [WARP_NUM-1:0]      GRT_raw_2_RR_IF;
  logic [WARP_NUM*PC_W-1:0] PCAll_PC_IF;
  logic [WARP_NUM-1:0]      Flush_TM_IF;
  logic                     Full_IF_RR;
  logic                     Req_IF_IC;
  logic [PC_W-1:0]          Addr_IF_IC;
  logic                     Ack_IC_IF;
  logic                     Miss_IC_IF;
  logic                     Refill_IC_IF;
  logic [PC_W-1:0]          Inst_IC_IF;
  logic                     Stall_ID_IF;
  logic                     Valid_IF_ID;
  logic [WidW-1:0]          WarpID_IF_ID;
  logic [PC_W-1:0]          PC_IF_ID;
  logic [PC_W-1:0]          Inst_IF_ID;
`ifdef FETCH_PERF_CNT_EN
  logic [15:0]              IssueCnt_IF_PERF;
  logic [15:0]              MissCyc_IF_PERF;
`endif

  // Sequencer side
  modport master (
`ifdef FETCH_PERF_CNT_EN
    output IssueCnt_IF_PERF, output MissCyc_IF_PERF,
`endif
    input  GRT_raw_1_RR_IF, input GRT_raw_2_RR_IF, input PCAll_PC_IF, input Flush_TM_IF,
    input  Ack_IC_IF, input Miss_IC_IF, input Refill_IC_IF, input Inst_IC_IF,
    input  Stall_ID_IF,
    output Full_IF_RR, output Req_IF_IC, output Addr_IF_IC,
    output Valid_IF_ID, output WarpID_IF_ID, output PC_IF_ID, output Inst_IF_ID
  );

  // Environment side
  modport slave (
`ifdef FETCH_PERF_CNT_EN
    input  IssueCnt_IF_PERF, input MissCyc_IF_PERF,
`endif
    output GRT_raw_1_RR_IF, output GRT_raw_2_RR_IF, output PCAll_PC_IF, output Flush_TM_IF,
    output Ack_IC_IF, output Miss_IC_IF, output Refill_IC_IF, output Inst_IC_IF,
    output Stall_ID_IF,
    input  Full_IF_RR, input Req_IF_IC, input Addr_IF_IC,
    input  Valid_IF_ID, input WarpID_IF_ID, input PC_IF_ID, input Inst_IF_ID
  );

endinterface

// File: rtl/fetch_warp_queue.sv
// 2-push/1-pop circular warp queue. Each entry has a live bit, and a per-warp kill vector
// clears it. A push whose warp is killed in the same cycle is discarded.
module fetch_warp_queue #(
  parameter int unsigned WARP_NUM = 8,
  parameter int unsigned QDEPTH   = 4,
  localparam int unsigned WidW    = $clog2(WARP_NUM),
  localparam int unsigned PtrW    = $clog2(QDEPTH),
  localparam int unsigned CntW    = PtrW + 1
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                push1_i,
  input  logic [WidW-1:0]     push1_id_i,
  input  logic                push2_i,
  input  logic [WidW-1:0]     push2_id_i,
  input  logic                pop_i,
  input  logic [WARP_NUM-1:0] kill_i,
  output logic                head_valid_o,
  output logic                head_live_o,
  output logic [WidW-1:0]     head_id_o,
  output logic [CntW-1:0]     count_o
);

  logic [WidW-1:0]   id_q [QDEPTH];
  logic [QDEPTH-1:0] live_q;
  logic [PtrW-1:0]   wr_ptr_q, rd_ptr_q, wr2_ptr;
  logic [CntW-1:0]   count_q;
  logic              push1_ok, push2_ok;

  // Flush wins over a same-cycle push. Push 2 follows push 1 only if push 1 was kept.
  always_comb begin
    push1_ok = push1_i & ~kill_i[push1_id_i];
    push2_ok = push2_i & ~kill_i[push2_id_i];
    wr2_ptr  = push1_ok ? wr_ptr_q + PtrW'(1) : wr_ptr_q;
  end

  // Pointers, count and live bits. Kills apply first, and new writes override them.
  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
      live_q   <= '0;
    end else begin
      for (int unsigned i = 0; i < QDEPTH; i++) begin
        if (kill_i[id_q[i]]) live_q[i] <= 1'b0;
      end
      if (push1_ok) live_q[wr_ptr_q] <= 1'b1;
      if (push2_ok) live_q[wr2_ptr] <= 1'b1;
      if (pop_i) rd_ptr_q <= rd_ptr_q + PtrW'(1);
      wr_ptr_q <= wr_ptr_q + PtrW'(push1_ok) + PtrW'(push2_ok);
      count_q  <= count_q + CntW'(push1_ok) + CntW'(push2_ok) - CntW'(pop_i);
    end
  end

  // Entry payload storage. It needs no reset because occupancy is tracked by the count.
  always_ff @(posedge clk) begin
    if (push1_ok) id_q[wr_ptr_q] <= push1_id_i;
    if (push2_ok) id_q[wr2_ptr] <= push2_id_i;
  end

  assign head_valid_o = (count_q != '0);
  assign head_live_o  = live_q[rd_ptr_q];
  assign head_id_o    = id_q[rd_ptr_q];
  assign count_o      = count_q;

endmodule

// File: rtl/fetch_issue_sequencer.sv
// Fetch/issue sequencer. It queues granted warps, issues one I-cache fetch at a time, rides out
// misses and delivers tagged instructions to decode.
// The FETCH_PERF_CNT_EN macro adds the issue and miss-cycle counters.
module fetch_issue_sequencer
  import fetch_pkg::*;
#(
  parameter int unsigned WARP_NUM = WARP_NUM_DEF,
  parameter int unsigned PC_W     = 32,
  parameter int unsigned QDEPTH   = 4
) (
  input logic                    clk,
  input logic                    rst,
  fetch_issue_sequencer_if.master bus
);

  localparam int unsigned WidW = $clog2(WARP_NUM);
  localparam int unsigned CntW = $clog2(QDEPTH) + 1;

  fetch_state_t    state_q, state_d;
  logic [CntW-1:0] count;
  logic            head_valid, head_live, head_live_now;
  logic [WidW-1:0] head_id, gnt1_id, gnt2_id;
  logic [PC_W-1:0] head_pc;
  logic            full, push1, push2, pop, req, load, out_free;

  logic            valid_q, valid_d;
  logic [WidW-1:0] wid_q, wid_d;
  logic [PC_W-1:0] pc_q, pc_d, inst_q, inst_d;

  // Encode grants and drop any that arrive while the queue is full.
  always_comb begin
    full    = (count > CntW'(QDEPTH - 2));
    gnt1_id = WidW'(onehot_to_idx(32'(bus.GRT_raw_1_RR_IF)));
    gnt2_id = WidW'(onehot_to_idx(32'(bus.GRT_raw_2_RR_IF)));
    push1   = (|bus.GRT_raw_1_RR_IF) & ~full;
    push2   = (|bus.GRT_raw_2_RR_IF) & ~full;
  end

  fetch_warp_queue #(
    .WARP_NUM (WARP_NUM),
    .QDEPTH   (QDEPTH)
  ) u_queue (
    .clk          (clk),
    .rst          (rst),
    .push1_i      (push1),
    .push1_id_i   (gnt1_id),
    .push2_i      (push2),
    .push2_id_i   (gnt2_id),
    .pop_i        (pop),
    .kill_i       (bus.Flush_TM_IF),
    .head_valid_o (head_valid),
    .head_live_o  (head_live),
    .head_id_o    (head_id),
    .count_o      (count)
  );

  // Live PC of the head warp
  always_comb begin
    head_pc = '0;
    for (int unsigned i = 0; i < WARP_NUM; i++) begin
      if (head_id == WidW'(i)) head_pc = bus.PCAll_PC_IF[i*PC_W +: PC_W];
    end
  end

  // Next-state logic and request control. IDLE issues in the same cycle it sees a live head,
  // which gives the grant-to-request latency of one cycle. A head flushed while in flight stays
  // queued until its Ack arrives, and that Ack pops it without loading the output.
  always_comb begin
    state_d       = state_q;
    req           = 1'b0;
    pop           = 1'b0;
    load          = 1'b0;
    head_live_now = head_valid & head_live & ~bus.Flush_TM_IF[head_id];
    out_free      = ~valid_q | ~bus.Stall_ID_IF;
    unique case (state_q)
      IDLE: begin
        if (head_valid && !head_live_now) begin
          pop = 1'b1;
        end else if (head_live_now && out_free) begin
          req     = 1'b1;
          state_d = REQ;
        end
      end
      REQ:  req = 1'b1;
      MISS: if (bus.Refill_IC_IF) state_d = REQ;
      default: state_d = IDLE;
    endcase
    if (req) begin
      if (bus.Ack_IC_IF) begin
        pop     = 1'b1;
        load    = head_live_now;
        state_d = IDLE;
      end else if (bus.Miss_IC_IF) begin
        state_d = MISS;
      end
    end
  end

  // Decode output register. It holds under stall and is cleared by consumption or by a flush
  // of the held warp.
  always_comb begin
    valid_d = valid_q;
    wid_d   = wid_q;
    pc_d    = pc_q;
    inst_d  = inst_q;
    if (load) begin
      valid_d = 1'b1;
      wid_d   = head_id;
      pc_d    = head_pc;
      inst_d  = bus.Inst_IC_IF;
    end else if (valid_q && (!bus.Stall_ID_IF || bus.Flush_TM_IF[wid_q])) begin
      valid_d = 1'b0;
    end
  end

  // State and output registers
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      valid_q <= 1'b0;
      wid_q   <= '0;
      pc_q    <= '0;
      inst_q  <= '0;
    end else begin
      state_q <= state_d;
      valid_q <= valid_d;
      wid_q   <= wid_d;
      pc_q    <= pc_d;
      inst_q  <= inst_d;
    end
  end

  assign bus.Full_IF_RR   = full;
  assign bus.Req_IF_IC    = req;
  assign bus.Addr_IF_IC   = req ? head_pc : '0;
  assign bus.Valid_IF_ID  = valid_q;
  assign bus.WarpID_IF_ID = wid_q;
  assign bus.PC_IF_ID     = pc_q;
  assign bus.Inst_IF_ID   = inst_q;

`ifdef FETCH_PERF_CNT_EN
  logic [15:0] issue_cnt_q, miss_cyc_q;

  // Saturating performance counters
  always_ff @(posedge clk) begin
    if (rst) begin
      issue_cnt_q <= '0;
      miss_cyc_q  <= '0;
    end else begin
      if (load && issue_cnt_q != 16'hFFFF) issue_cnt_q <= issue_cnt_q + 16'd1;
      if (state_q == MISS && miss_cyc_q != 16'hFFFF) miss_cyc_q <= miss_cyc_q + 16'd1;
    end
  end

  assign bus.IssueCnt_IF_PERF = issue_cnt_q;
  assign bus.MissCyc_IF_PERF  = miss_cyc_q;
`endif

  // Illegal stimulus: grants while full, or hit and miss together
  a_no_grant_when_full: assert property (@(posedge clk) disable iff (rst)
    !(full && ((|bus.GRT_raw_1_RR_IF) || (|bus.GRT_raw_2_RR_IF))));
  a_no_ack_and_miss: assert property (@(posedge clk) disable iff (rst)
    !(req && bus.Ack_IC_IF && bus.Miss_IC_IF));

endmodule

// File: tb/tb_fetch_issue_sequencer.sv
// Directed self-checking bench for fetch_issue_sequencer.
module tb_fetch_issue_sequencer;
  import fetch_pkg::*;

  localparam int unsigned WN = WARP_NUM_DEF;
  localparam int unsigned PW = 32;

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   checks = 0;
  int   failures = 0;

  always #5 clk = ~clk;

  fetch_issue_sequencer_if #(.WARP_NUM(WN), .PC_W(PW)) bus ();

  fetch_issue_sequencer #(.WARP_NUM(WN), .PC_W(PW), .QDEPTH(4)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  function automatic logic [31:0] pc_of(input int unsigned w);
    return 32'h1000 + 32'(w) * 32'h10;
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic drive(input logic [7:0] g1, input logic [7:0] g2, input logic ack,
                       input logic miss, input logic refill, input logic [7:0] flush,
                       input logic stall, input logic [31:0] inst);
    bus.GRT_raw_1_RR_IF = g1;
    bus.GRT_raw_2_RR_IF = g2;
    bus.Ack_IC_IF       = ack;
    bus.Miss_IC_IF      = miss;
    bus.Refill_IC_IF    = refill;
    bus.Flush_TM_IF     = flush;
    bus.Stall_ID_IF     = stall;
    bus.Inst_IC_IF      = inst;
    #1;
  endtask

  task automatic nxt();
    @(posedge clk);
    #2;
  endtask

  task automatic chk_out(input string tag, input int unsigned w, input logic [31:0] inst);
    chk({tag, "_valid"}, 32'(bus.Valid_IF_ID), 32'd1);
    chk({tag, "_wid"}, 32'(bus.WarpID_IF_ID), 32'(w));
    chk({tag, "_pc"}, bus.PC_IF_ID, pc_of(w));
    chk({tag, "_inst"}, bus.Inst_IF_ID, inst);
  endtask

  initial begin
    for (int unsigned w = 0; w < WN; w++) bus.PCAll_PC_IF[w*PW +: PW] = pc_of(w);
    drive(8'h00, 8'h00, 1'b0, 1'b0, 1'b0, 8'h00, 1'b0, 32'h0);
    nxt();
    nxt();
    chk("rst_full", 32'(bus.Full_IF_RR), 32'd0);
    chk("rst_req", 32'(bus.Req_IF_IC), 32'd0);
    chk("rst_valid", 32'(bus.Valid_IF_ID), 32'd0);
    chk("rst_addr", bus.Addr_IF_IC, 32'd0);

    // Two grants, hits every cycle
    rst = 1'b0;
    drive(8'h04, 8'h10, 1'b1, 1'b0, 1'b0, 8'h00, 1'b0, 32'h0);
    chk("t1_c0_req", 32'(bus.Req_IF_IC), 32'd0);
    nxt();
    drive(8'h00, 8'h00, 1'b1, 1'b0, 1'b0, 8'h00, 1'b0, 32'hC0DE0002);
    chk("t1_c1_req", 32'(bus.Req_IF_IC), 32'd1);
    chk("t1_c1_addr", bus.Addr_IF_IC, pc_of(2));
    chk("t1_c1_full", 32'(bus.Full_IF_RR), 32'd0);
    nxt();
    drive(8'h00, 8'h00, 1'b1, 1'b0, 1'b0, 8'h00, 1'b0, 32'hC0DE0004);
    chk_out("t1_c2", 2, 32'hC0DE0002);
    chk("t1_c2_addr", bus.Addr_IF_IC, pc_of(4));
    nxt();
    drive(8'h00, 8'h00, 1'b0, 1'b0, 1'b0, 8'h00, 1'b0, 32'h0);
    chk_out("t1_c3", 4, 32'hC0DE0004);
    chk("t1_c3_req", 32'(bus.Req_IF_IC), 32'd0);
    nxt();
    chk("t1_c4_valid", 32'(bus.Valid_IF_ID), 32'd0);

    // Miss on warp 3, refill at cycle 6
    drive(8'h08, 8'h00, 1'b0, 1'b0, 1'b0, 8'h00, 1'b0, 32'h0);
    nxt();
    drive(8'h00, 8'h00, 1'b0, 1'b1, 1'b0, 8'h00, 1'b0, 32'h0);
    chk("t2_c1_req", 32'(bus.Req_IF_IC), 32'd1);
    chk("t2_c1_addr", bus.Addr_IF_IC, pc_of(3));
    for (int c = 2; c <= 6; c++) begin
      nxt();
      drive(8'h00, 8'h00, 1'b0, 1'b0, (c == 6), 8'h00, 1'b0, 32'h0);
      chk($sformatf("t2_c%0d_req", c), 32'(bus.Req_IF_IC), 32'd0);
    end
    nxt();
    drive(8'h00, 8'h00, 1'b1, 1'b0, 1'b0, 8'h00, 1'b0, 32'hBEEF0003);
    chk("t2_c7_req", 32'(bus.Req_IF_IC), 32'd1);
    chk("t2_c7_addr", bus.Addr_IF_IC, pc_of(3));
    chk("t2_c7_valid", 32'(bus.Valid_IF_ID), 32'd0);
    nxt();
    drive(8'h00, 8'h00, 1'b0, 1'b0, 1'b0, 8'h00, 1'b0, 32'h0);
    chk_out("t2_c8", 3, 32'hBEEF0003);
    nxt();

    // Fill under stall, then release
    drive(8'h01, 8'h00, 1'b1, 1'b0, 1'b0, 8'h00, 1'b1, 32'hA0000000);
    chk("t3_c0_valid", 32'(bus.Valid_IF_ID), 32'd0);
    nxt();
    drive(8'h00, 8'h00, 1'b1, 1'b0, 1'b0, 8'h00, 1'b1, 32'hA0000000);
    chk("t3_c1_req", 32'(bus.Req_IF_IC), 32'd1);
    chk("t3_c1_addr", bus.Addr_IF_IC, pc_of(0));
    nxt();
    drive(8'h02, 8'h04, 1'b1, 1'b0, 1'b0, 8'h00, 1'b1, 32'h0);
    chk("t3_c2_req", 32'(bus.Req_IF_IC), 32'd0);
    chk("t3_c2_full", 32'(bus.Full_IF_RR), 32'd0);
    nxt();
    drive(8'h40, 8'h00, 1'b1, 1'b0, 1'b0, 8'h00, 1'b1, 32'h0);
    chk("t3_c3_full", 32'(bus.Full_IF_RR), 32'd0);
    chk("t3_c3_req", 32'(bus.Req_IF_IC), 32'd0);
    nxt();
    drive(8'h00, 8'h00, 1'b1, 1'b0, 1'b0, 8'h00, 1'b1, 32'h0);
    chk("t3_c4_full", 32'(bus.Full_IF_RR), 32'd1);
    chk("t3_c4_req", 32'(bus.Req_IF_IC), 32'd0);
    chk_out("t3_c4", 0, 32'hA0000000);
    nxt();
    drive(8'h00, 8'h00, 1'b1, 1'b0, 1'b0, 8'h00, 1'b0, 32'hA0000001);
    chk("t3_c5_full", 32'(bus.Full_IF_RR), 32'd1);
    chk("t3_c5_addr", bus.Addr_IF_IC, pc_of(1));
    chk_out("t3_c5", 0, 32'hA0000000);
    nxt();
    drive(8'h00, 8'h00, 1'b1, 1'b0, 1'b0, 8'h00, 1'b0, 32'hA0000002);
    chk("t3_c6_full", 32'(bus.Full_IF_RR), 32'd0);
    chk_out("t3_c6", 1, 32'hA0000001);
    chk("t3_c6_addr", bus.Addr_IF_IC, pc_of(2));
    nxt();
    drive(8'h00, 8'h00, 1'b1, 1'b0, 1'b0, 8'h00, 1'b0, 32'hA0000006);
    chk_out("t3_c7", 2, 32'hA0000002);
    chk("t3_c7_addr", bus.Addr_IF_IC, pc_of(6));
    nxt();
    drive(8'h00, 8'h00, 1'b0, 1'b0, 1'b0, 8'h00, 1'b0, 32'h0);
    chk_out("t3_c8", 6, 32'hA0000006);
    chk("t3_c8_req", 32'(bus.Req_IF_IC), 32'd0);
    nxt();
    chk("t3_c9_valid", 32'(bus.Valid_IF_ID), 32'd0);
    nxt();

    // Flush warp 5 while in MISS with a second warp-5 entry queued
    drive(8'h20, 8'h00, 1'b0, 1'b0, 1'b0, 8'h00, 1'b0, 32'h0);
    nxt();
    drive(8'h20, 8'h80, 1'b0, 1'b1, 1'b0, 8'h00, 1'b0, 32'h0);
    chk("t4_c1_addr", bus.Addr_IF_IC, pc_of(5));
    nxt();
    drive(8'h00, 8'h00, 1'b0, 1'b0, 1'b0, 8'h20, 1'b0, 32'h0);
    chk("t4_c2_req", 32'(bus.Req_IF_IC), 32'd0);
    nxt();
    drive(8'h00, 8'h00, 1'b0, 1'b0, 1'b0, 8'h00, 1'b0, 32'h0);
    chk("t4_c3_req", 32'(bus.Req_IF_IC), 32'd0);
    nxt();
    drive(8'h00, 8'h00, 1'b0, 1'b0, 1'b1, 8'h00, 1'b0, 32'h0);
    chk("t4_c4_req", 32'(bus.Req_IF_IC), 32'd0);
    nxt();
    drive(8'h00, 8'h00, 1'b1, 1'b0, 1'b0, 8'h00, 1'b0, 32'hD0000005);
    chk("t4_c5_req", 32'(bus.Req_IF_IC), 32'd1);
    chk("t4_c5_addr", bus.Addr_IF_IC, pc_of(5));
    nxt();
    drive(8'h00, 8'h00, 1'b1, 1'b0, 1'b0, 8'h00, 1'b0, 32'hD0000005);
    chk("t4_c6_valid", 32'(bus.Valid_IF_ID), 32'd0);
    chk("t4_c6_req", 32'(bus.Req_IF_IC), 32'd0);
    nxt();
    drive(8'h00, 8'h00, 1'b1, 1'b0, 1'b0, 8'h00, 1'b0, 32'hD0000007);
    chk("t4_c7_valid", 32'(bus.Valid_IF_ID), 32'd0);
    chk("t4_c7_addr", bus.Addr_IF_IC, pc_of(7));
    nxt();
    drive(8'h00, 8'h00, 1'b0, 1'b0, 1'b0, 8'h00, 1'b0, 32'h0);
    chk_out("t4_c8", 7, 32'hD0000007);
    nxt();

    // Same-cycle grant and flush of warp 1; warp 7 granted alongside
    drive(8'h02, 8'h80, 1'b1, 1'b0, 1'b0, 8'h02, 1'b0, 32'h0);
    chk("t5_c0_valid", 32'(bus.Valid_IF_ID), 32'd0);
    nxt();
    drive(8'h00, 8'h00, 1'b1, 1'b0, 1'b0, 8'h00, 1'b0, 32'hE0000007);
    chk("t5_c1_addr", bus.Addr_IF_IC, pc_of(7));
    nxt();
    drive(8'h00, 8'h00, 1'b1, 1'b0, 1'b0, 8'h00, 1'b0, 32'hE0000001);
    chk_out("t5_c2", 7, 32'hE0000007);
    chk("t5_c2_req", 32'(bus.Req_IF_IC), 32'd0);
    nxt();
    drive(8'h00, 8'h00, 1'b0, 1'b0, 1'b0, 8'h00, 1'b0, 32'h0);
    chk("t5_c3_valid", 32'(bus.Valid_IF_ID), 32'd0);
    chk("t5_c3_req", 32'(bus.Req_IF_IC), 32'd0);
    nxt();

    // Reset during MISS, then a stray refill and ack
    drive(8'h08, 8'h00, 1'b0, 1'b0, 1'b0, 8'h00, 1'b0, 32'h0);
    nxt();
    drive(8'h00, 8'h00, 1'b0, 1'b1, 1'b0, 8'h00, 1'b0, 32'h0);
    chk("t6_c1_req", 32'(bus.Req_IF_IC), 32'd1);
    nxt();
    rst = 1'b1;
    drive(8'h00, 8'h00, 1'b0, 1'b0, 1'b0, 8'h00, 1'b0, 32'h0);
    chk("t6_c2_req", 32'(bus.Req_IF_IC), 32'd0);
    nxt();
    rst = 1'b0;
    drive(8'h00, 8'h00, 1'b0, 1'b0, 1'b1, 8'h00, 1'b0, 32'h0);
    chk("t6_c3_req", 32'(bus.Req_IF_IC), 32'd0);
    chk("t6_c3_full", 32'(bus.Full_IF_RR), 32'd0);
    chk("t6_c3_addr", bus.Addr_IF_IC, 32'd0);
    chk("t6_c3_valid", 32'(bus.Valid_IF_ID), 32'd0);
    chk("t6_c3_wid", 32'(bus.WarpID_IF_ID), 32'd0);
    chk("t6_c3_pc", bus.PC_IF_ID, 32'd0);
    chk("t6_c3_inst", bus.Inst_IF_ID, 32'd0);
    nxt();
    drive(8'h00, 8'h00, 1'b1, 1'b0, 1'b0, 8'h00, 1'b0, 32'h12345678);
    chk("t6_c4_req", 32'(bus.Req_IF_IC), 32'd0);
    chk("t6_c4_addr", bus.Addr_IF_IC, 32'd0);
    nxt();
    drive(8'h00, 8'h00, 1'b0, 1'b0, 1'b0, 8'h00, 1'b0, 32'h0);
    chk("t6_c5_valid", 32'(bus.Valid_IF_ID), 32'd0);
    chk("t6_c5_req", 32'(bus.Req_IF_IC), 32'd0);
    chk("t6_c5_inst", bus.Inst_IF_ID, 32'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
